clock_crossing_slave_arbiter: RTL and testbench
===============================================

// Module: clock_crossing_slave_arbiter
// PURPOSE
//  Shares the slave_clk-side Avalon-MM port of the clock_crossing bridge between two requesters (r0, r1).
//  Round-robin grant per transfer; tracks outstanding reads in a tag FIFO to route readdatavalid back.
//  Sits in the slave_clk domain, directly upstream of the bridge's slave port.
// PARAMETERS
//  ADDR_W   28  word address width (matches bridge slave_address / slave_nativeaddress)
//  DATA_W   32  data width
//  MAX_OUT  16  max outstanding reads, power of 2, >=2; tag FIFO depth
// PORTS
//  slave_clk        in   1        clock
//  slave_reset_n    in   1        asynchronous, active-low reset
//  rN_address       in   ADDR_W   requester N word address (N=0,1)
//  rN_byteenable    in   4        requester N byte enables
//  rN_read          in   1        requester N read request
//  rN_write         in   1        requester N write request
//  rN_writedata     in   DATA_W   requester N write data
//  rN_waitrequest   out  1        0 only in the cycle requester N's command is accepted
//  rN_readdatavalid out  1        read data valid for requester N
//  r_readdata       out  DATA_W   read data, shared by both requesters
//  cc_address       out  ADDR_W   to bridge slave_address
//  cc_nativeaddress out  ADDR_W   to bridge slave_nativeaddress (same value as cc_address)
//  cc_byteenable    out  4        to bridge
//  cc_read          out  1        to bridge
//  cc_write         out  1        to bridge
//  cc_writedata     out  DATA_W   to bridge
//  cc_waitrequest   in   1        from bridge slave_waitrequest
//  cc_readdata      in   DATA_W   from bridge
//  cc_readdatavalid in   1        from bridge
//  err_unexp_rdv    out  1        sticky: readdatavalid seen with tag FIFO empty
//  r0_grant_cnt     out  32       accepted transfers r0 (see CONFIGURATION)
//  r1_grant_cnt     out  32       accepted transfers r1
// BEHAVIOUR
//  Reset: FSM=IDLE, rr pointer last=1 (r0 preferred first), tag FIFO empty, err_unexp_rdv=0, counters=0;
//   rN_waitrequest=1, cc_read=cc_write=0, rN_readdatavalid=0.
//  Eligible(N) = rN_write | (rN_read & ~tag_full). rN_read&rN_write both high: read has precedence.
//  IDLE: if any eligible -> sel = eligible ~last ? ~last : other; register sel; -> ISSUE. 1 cycle arb latency.
//  ISSUE: cc_* driven combinationally from requester sel (cc_read/cc_write = rsel_read/rsel_write, read wins).
//   cc_waitrequest=1: hold; rsel must keep signals stable (Avalon rule), arbiter never re-arbitrates.
//   cc_waitrequest=0: accept; rsel_waitrequest=0 this cycle; push sel into tag FIFO if read;
//    last<=sel; -> IDLE. Min 2 cycles per transfer; back-to-back requester alternates when both active.
//  Requester drops request while in ISSUE (protocol violation): cc_read/write follow it low; return to IDLE
//   next cycle without push or counter update.
//  Tag FIFO: depth MAX_OUT, 1-bit entries, count width log2(MAX_OUT)+1; pointers wrap mod MAX_OUT.
//   tag_full blocks new read grants only; writes still granted when full.
//   Push and pop same cycle: count unchanged, both pointers advance; pop from full allowed.
//  Return: on cc_readdatavalid pop head; rN_readdatavalid = cc_readdatavalid & ~empty & (head==N),
//   combinational, zero latency; r_readdata = cc_readdata unregistered.
//   cc_readdatavalid with empty FIFO: no requester valid, err_unexp_rdv<=1 until reset.
//  Reset mid-operation: all state cleared immediately; in-flight bridge responses are dropped
//   and flagged via err_unexp_rdv (bridge downstream FIFO shares this reset).
// CONFIGURATION
//  CC_ARB_PERF_CNT_EN defined: rN_grant_cnt increments on each accepted transfer of N, saturates at
//   32'hFFFF_FFFF, cleared only by reset.
//  Not defined: counters not built, r0_grant_cnt/r1_grant_cnt tied to 32'd0.
// TESTING
//  r0 write 0x10=0xA5A5A5A5, r1 idle, cc_waitrequest=0 -> cc_write in cycle 2, r0_waitrequest=0 once.
//  r0,r1 both read continuously, no wait -> grants alternate r0,r1,r0,...; tags 0,1,0 routed on return.
//  cc_waitrequest=1 for 5 cycles in ISSUE -> cc_* stable, r*_waitrequest=1, grant unchanged.
//  16 reads no returns -> 17th read blocked; r1 write still accepted; one return frees a read grant.
//  Push+pop same cycle at count=16 -> count stays 16, correct routing order preserved.
//  cc_readdatavalid after reset with 4 reads pending -> no rN_readdatavalid, err_unexp_rdv=1;
//   with CC_ARB_PERF_CNT_EN, 3 r0 + 2 r1 transfers -> r0_grant_cnt=3, r1_grant_cnt=2.

Source files
------------

// File: rtl/clock_crossing_slave_arbiter.sv
// clock_crossing_slave_arbiter: round-robin share of the bridge slave port between two requesters
//   Clock/reset: slave_clk, slave_reset_n (asynchronous, active-low).
//   Requester side: rN_address/byteenable/read/write/writedata in, rN_waitrequest/rN_readdatavalid out,
//     r_readdata shared read data out.
//   Bridge side: cc_address/nativeaddress/byteenable/read/write/writedata out,
//     cc_waitrequest/readdata/readdatavalid in.
//   Status: err_unexp_rdv (sticky unexpected read data), r0_grant_cnt/r1_grant_cnt.
//   Optional macro CC_ARB_PERF_CNT_EN builds saturating per-requester accepted-transfer counters;
//   without it the counter outputs are tied to zero.
module clock_crossing_slave_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 16
) (
    input  logic              slave_clk,
    input  logic              slave_reset_n,
    input  logic [ADDR_W-1:0] r0_address,
    input  logic [3:0]        r0_byteenable,
    input  logic              r0_read,
    input  logic              r0_write,
    input  logic [DATA_W-1:0] r0_writedata,
    output logic              r0_waitrequest,
    output logic              r0_readdatavalid,
    input  logic [ADDR_W-1:0] r1_address,
    input  logic [3:0]        r1_byteenable,
    input  logic              r1_read,
    input  logic              r1_write,
    input  logic [DATA_W-1:0] r1_writedata,
    output logic              r1_waitrequest,
    output logic              r1_readdatavalid,
    output logic [DATA_W-1:0] r_readdata,
    output logic [ADDR_W-1:0] cc_address,
    output logic [ADDR_W-1:0] cc_nativeaddress,
    output logic [3:0]        cc_byteenable,
    output logic              cc_read,
    output logic              cc_write,
    output logic [DATA_W-1:0] cc_writedata,
    input  logic              cc_waitrequest,
    input  logic [DATA_W-1:0] cc_readdata,
    input  logic              cc_readdatavalid,
    output logic              err_unexp_rdv,
    output logic [31:0]       r0_grant_cnt,
    output logic [31:0]       r1_grant_cnt
);
    localparam int AW = $clog2(MAX_OUT);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t       state, state_n;
    logic         sel, sel_n, last;
    logic [AW-1:0] wp, rp;
    logic [AW:0]  cnt;
    logic [MAX_OUT-1:0] tags;
    logic         empty, full, e0, e1, rsel_read, rsel_write, pop, push, accept;

    assign empty = cnt == '0;
    assign full  = cnt == (AW+1)'(MAX_OUT);
    assign e0    = r0_write | (r0_read & ~full);
    assign e1    = r1_write | (r1_read & ~full);
    assign rsel_read  = sel ? r1_read : r0_read;
    assign rsel_write = sel ? r1_write : r0_write;
    assign pop   = cc_readdatavalid & ~empty;
    assign push  = accept & cc_read;

    assign cc_address       = sel ? r1_address : r0_address;
    assign cc_nativeaddress = cc_address;
    assign cc_byteenable    = sel ? r1_byteenable : r0_byteenable;
    assign cc_writedata     = sel ? r1_writedata : r0_writedata;

    assign r0_waitrequest   = ~(accept & ~sel);
    assign r1_waitrequest   = ~(accept & sel);
    assign r0_readdatavalid = pop & ~tags[rp];
    assign r1_readdatavalid = pop & tags[rp];
    assign r_readdata       = cc_readdata;

    always_comb begin
        state_n  = state;
        sel_n    = sel;
        cc_read  = 1'b0;
        cc_write = 1'b0;
        accept   = 1'b0;
        if (state == IDLE) begin
            if (e0 | e1) begin
                // prefer the requester not served last, else take the other one
                sel_n   = (last ? e0 : e1) ? ~last : last;
                state_n = ISSUE;
            end
        end else begin
            // a read+write requester granted through its write while the FIFO is full may
            // only issue the read if a slot frees this very cycle; otherwise its write goes
            cc_read  = rsel_read & (~full | pop);
            cc_write = rsel_write & ~cc_read;
            if (~(rsel_read | rsel_write))
                state_n = IDLE;
            else if ((cc_read | cc_write) & ~cc_waitrequest) begin
                accept  = 1'b1;
                state_n = IDLE;
            end
        end
    end

    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            state         <= IDLE;
            sel           <= 1'b0;
            last          <= 1'b1;
            wp            <= '0;
            rp            <= '0;
            cnt           <= '0;
            err_unexp_rdv <= 1'b0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            if (accept) last <= sel;
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            if (cc_readdatavalid & empty) err_unexp_rdv <= 1'b1;
        end
    end

    // tag storage needs no reset: only entries between rp and wp are ever read
    always_ff @(posedge slave_clk) begin
        if (push) tags[wp] <= sel;
    end

`ifdef CC_ARB_PERF_CNT_EN
    logic [31:0] c0, c1;

    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            c0 <= '0;
            c1 <= '0;
        end else begin
            if (accept & ~sel & ~&c0) c0 <= c0 + 1'b1;
            if (accept & sel & ~&c1) c1 <= c1 + 1'b1;
        end
    end

    assign r0_grant_cnt = c0;
    assign r1_grant_cnt = c1;
`else
    assign r0_grant_cnt = 32'd0;
    assign r1_grant_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_clock_crossing_slave_arbiter.sv
// tb_clock_crossing_slave_arbiter: scoreboard bench for the two-requester bridge arbiter
module tb_clock_crossing_slave_arbiter;
    logic        slave_clk = 1'b0;
    logic        slave_reset_n = 1'b0;
    logic [27:0] r0_address = '0, r1_address = '0;
    logic [3:0]  r0_byteenable = '0, r1_byteenable = '0;
    logic        r0_read = 0, r0_write = 0, r1_read = 0, r1_write = 0;
    logic [31:0] r0_writedata = '0, r1_writedata = '0;
    logic        r0_waitrequest, r1_waitrequest, r0_readdatavalid, r1_readdatavalid;
    logic [31:0] r_readdata;
    logic [27:0] cc_address, cc_nativeaddress;
    logic [3:0]  cc_byteenable;
    logic        cc_read, cc_write;
    logic [31:0] cc_writedata;
    logic        cc_waitrequest = 0;
    logic [31:0] cc_readdata = '0;
    logic        cc_readdatavalid = 0;
    logic        err_unexp_rdv;
    logic [31:0] r0_grant_cnt, r1_grant_cnt;

    int total = 0, bad = 0;
    bit exp_tag[$];
    logic [31:0] exp_data[$];

    clock_crossing_slave_arbiter dut (
        .slave_clk(slave_clk), .slave_reset_n(slave_reset_n),
        .r0_address(r0_address), .r0_byteenable(r0_byteenable), .r0_read(r0_read),
        .r0_write(r0_write), .r0_writedata(r0_writedata), .r0_waitrequest(r0_waitrequest),
        .r0_readdatavalid(r0_readdatavalid),
        .r1_address(r1_address), .r1_byteenable(r1_byteenable), .r1_read(r1_read),
        .r1_write(r1_write), .r1_writedata(r1_writedata), .r1_waitrequest(r1_waitrequest),
        .r1_readdatavalid(r1_readdatavalid), .r_readdata(r_readdata),
        .cc_address(cc_address), .cc_nativeaddress(cc_nativeaddress), .cc_byteenable(cc_byteenable),
        .cc_read(cc_read), .cc_write(cc_write), .cc_writedata(cc_writedata),
        .cc_waitrequest(cc_waitrequest), .cc_readdata(cc_readdata),
        .cc_readdatavalid(cc_readdatavalid), .err_unexp_rdv(err_unexp_rdv),
        .r0_grant_cnt(r0_grant_cnt), .r1_grant_cnt(r1_grant_cnt)
    );

    always #5 slave_clk = ~slave_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge slave_clk);
        #1;
    endtask

    task automatic do_reset();
        slave_reset_n = 1'b0;
        cyc();
        cyc();
        slave_reset_n = 1'b1;
    endtask

    task automatic set_req(input int id, input logic rd, input logic wr,
                           input logic [27:0] a, input logic [31:0] d);
        if (id == 0) begin
            r0_read = rd; r0_write = wr; r0_address = a; r0_writedata = d; r0_byteenable = 4'hF;
        end else begin
            r1_read = rd; r1_write = wr; r1_address = a; r1_writedata = d; r1_byteenable = 4'hF;
        end
    endtask

    // hold one command until its waitrequest drops, then release it after the accepting edge
    task automatic xfer(input int id, input logic rd, input logic [27:0] a, input logic [31:0] d);
        bit ok = 0;
        set_req(id, rd, ~rd, a, d);
        for (int i = 0; i < 12; i++) begin
            #1;
            if (id == 0 ? !r0_waitrequest : !r1_waitrequest) begin
                ok = 1;
                break;
            end
            cyc();
        end
        check("xfer_accept", ok, 1);
        cyc();
        set_req(id, 0, 0, '0, '0);
    endtask

    task automatic ret(input string tag, input logic [31:0] d);
        bit t;
        cc_readdatavalid = 1;
        cc_readdata = d;
        #1;
        if (exp_tag.size() == 0) check({tag, "_sb_empty"}, 1, 0);
        else begin
            t = exp_tag.pop_front();
            check({tag, "_rdv0"}, r0_readdatavalid, t == 0);
            check({tag, "_rdv1"}, r1_readdatavalid, t == 1);
            check({tag, "_data"}, r_readdata, d);
        end
        cyc();
        cc_readdatavalid = 0;
    endtask

    initial begin
        int n, hits;
        logic [31:0] e0c, e1c;
        // reset state
        #2;
        check("rst_wr0", r0_waitrequest, 1);
        check("rst_wr1", r1_waitrequest, 1);
        check("rst_ccrd", cc_read, 0);
        check("rst_ccwr", cc_write, 0);
        check("rst_rdv0", r0_readdatavalid, 0);
        check("rst_err", err_unexp_rdv, 0);
        check("rst_cnt0", r0_grant_cnt, 0);
        check("rst_cnt1", r1_grant_cnt, 0);
        cyc();
        slave_reset_n = 1;

        // single write: one cycle of arbitration then issue
        set_req(0, 0, 1, 28'h10, 32'hA5A5A5A5);
        #1;
        check("w_idle_ccwr", cc_write, 0);
        check("w_idle_wr0", r0_waitrequest, 1);
        cyc();
        check("w_ccwr", cc_write, 1);
        check("w_ccrd", cc_read, 0);
        check("w_addr", cc_address, 28'h10);
        check("w_naddr", cc_nativeaddress, 28'h10);
        check("w_data", cc_writedata, 32'hA5A5A5A5);
        check("w_be", cc_byteenable, 4'hF);
        check("w_wr0", r0_waitrequest, 0);
        check("w_wr1", r1_waitrequest, 1);
        cyc();
        set_req(0, 0, 0, '0, '0);
        #1;
        check("w_after_wr0", r0_waitrequest, 1);
        check("w_after_ccwr", cc_write, 0);

        // both read continuously: grants alternate starting with r0
        do_reset();
        set_req(0, 1, 0, 28'h100, '0);
        set_req(1, 1, 0, 28'h200, '0);
        for (int i = 0; i < 6; i++) exp_tag.push_back(i[0]);
        n = 0;
        for (int i = 0; i < 40 && n < 6; i++) begin
            #1;
            if (cc_read && !cc_waitrequest) begin
                check("alt_grant", r1_waitrequest, exp_tag[n] == 0);
                check("alt_addr", cc_address, exp_tag[n] ? 28'h200 : 28'h100);
                n++;
            end
            cyc();
        end
        check("alt_count", n, 6);
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        for (int i = 0; i < 6; i++) ret("alt_ret", 32'hD000 + i);

        // bridge stall: command held, no re-arbitration
        set_req(0, 0, 1, 28'h33, 32'h3333);
        cc_waitrequest = 1;
        cyc();
        set_req(1, 0, 1, 28'h44, 32'h4444);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("hold_addr", cc_address, 28'h33);
            check("hold_ccwr", cc_write, 1);
            check("hold_wr0", r0_waitrequest, 1);
            check("hold_wr1", r1_waitrequest, 1);
            cyc();
        end
        cc_waitrequest = 0;
        #1;
        check("hold_rel_wr0", r0_waitrequest, 0);
        check("hold_rel_wr1", r1_waitrequest, 1);
        cyc();
        set_req(0, 0, 0, '0, '0);
        n = 0;
        for (int i = 0; i < 6 && n == 0; i++) begin
            #1;
            if (!r1_waitrequest) begin
                check("hold_r1_addr", cc_address, 28'h44);
                n = 1;
            end
            cyc();
        end
        check("hold_r1_acc", n, 1);
        set_req(1, 0, 0, '0, '0);

        // fill the tag FIFO with 16 r0 reads
        do_reset();
        set_req(0, 1, 0, 28'h500, '0);
        n = 0;
        for (int i = 0; i < 60 && n < 16; i++) begin
            #1;
            if (cc_read && !cc_waitrequest) begin
                exp_tag.push_back(0);
                n++;
            end
            cyc();
        end
        check("fill_count", n, 16);
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (cc_read) hits++;
            cyc();
        end
        check("full_blocked", hits, 0);
        xfer(1, 0, 28'h44, 32'h44);
        ret("full_ret", 32'hE0);
        n = 0;
        for (int i = 0; i < 6 && n == 0; i++) begin
            #1;
            if (cc_read && !cc_waitrequest && !r0_waitrequest) begin
                exp_tag.push_back(0);
                n = 1;
            end
            cyc();
        end
        check("freed_grant", n, 1);
        set_req(0, 0, 0, '0, '0);
        // push and pop in the same cycle at full
        set_req(1, 1, 1, 28'h55, 32'h55);
        cyc();
        cc_readdatavalid = 1;
        cc_readdata = 32'hF1;
        #1;
        check("pp_ccrd", cc_read, 1);
        check("pp_ccwr", cc_write, 0);
        check("pp_wr1", r1_waitrequest, 0);
        check("pp_rdv0", r0_readdatavalid, exp_tag.pop_front() == 0);
        exp_tag.push_back(1);
        cyc();
        cc_readdatavalid = 0;
        set_req(1, 0, 0, '0, '0);
        set_req(0, 1, 0, 28'h500, '0);
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (cc_read) hits++;
            cyc();
        end
        check("pp_still_full", hits, 0);
        set_req(0, 0, 0, '0, '0);
        for (int i = 0; i < 16; i++) ret("drain", 32'h100 + i);
        #1;
        check("drain_err", err_unexp_rdv, 0);

        // reset with reads in flight: late responses are flagged, not routed
        do_reset();
        for (int i = 0; i < 4; i++) xfer(0, 1, 28'h600 + i, '0);
        #3;
        slave_reset_n = 0;
        #2;
        slave_reset_n = 1;
        cyc();
        cc_readdatavalid = 1;
        #1;
        check("late_rdv0", r0_readdatavalid, 0);
        check("late_rdv1", r1_readdatavalid, 0);
        cyc();
        cc_readdatavalid = 0;
        #1;
        check("late_err", err_unexp_rdv, 1);

        // grant counters
        do_reset();
        for (int i = 0; i < 3; i++) xfer(0, 0, 28'h700, 32'h7);
        for (int i = 0; i < 2; i++) xfer(1, 0, 28'h800, 32'h8);
`ifdef CC_ARB_PERF_CNT_EN
        e0c = 3;
        e1c = 2;
`else
        e0c = 0;
        e1c = 0;
`endif
        #1;
        check("cnt0", r0_grant_cnt, e0c);
        check("cnt1", r1_grant_cnt, e1c);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
